// File: rtl/completion_command_channel_fifo.sv
// completion_command_channel_fifo
//
// Command channel between a command source and the downstream command bus.
// Each accepted command is handled in one of three ways:
//   - addressed to this node (ThisID): replaced by a completion report
//   - foreign and zero-length: dropped, with a saturating drop counter
//   - anything else: forwarded unchanged
// Results go into a Depth-entry first-word-fall-through queue, so the source
// is not stalled while the destination is busy.
//
// Ports:
//   iClock, iReset          clock, synchronous active-high reset
//   iSrc*                   incoming command fields, valid and qualifier
//   oSrcCmdReady            source may present a command this cycle
//   oDst*                   head-of-queue command fields and valid
//   iDstCmdReady            destination consumes the head entry
//   oQueueCount             current occupancy, 0..Depth
//   oDropCount              saturating count of dropped zero-length commands
module completion_command_channel_fifo #(
   parameter int AddressWidth       = 32,
   parameter int InnerIFLengthWidth = 16,
   parameter int ThisID             = 1,
   parameter int Depth              = 4,
   parameter int DepthWidth         = 2,
   parameter int CmpltOpcode        = 0,
   parameter int CmpltToSource      = 0
) (
   input  logic                          iClock,
   input  logic                          iReset,
   input  logic [5:0]                    iSrcOpcode,
   input  logic [4:0]                    iSrcTargetID,
   input  logic [4:0]                    iSrcSourceID,
   input  logic [AddressWidth-1:0]       iSrcAddress,
   input  logic [InnerIFLengthWidth-1:0] iSrcLength,
   input  logic                          iSrcCmdValid,
   output logic                          oSrcCmdReady,
   input  logic                          iSrcValidCond,
   output logic [5:0]                    oDstOpcode,
   output logic [4:0]                    oDstTargetID,
   output logic [4:0]                    oDstSourceID,
   output logic [AddressWidth-1:0]       oDstAddress,
   output logic [InnerIFLengthWidth-1:0] oDstLength,
   output logic                          oDstCmdValid,
   input  logic                          iDstCmdReady,
   output logic [DepthWidth:0]           oQueueCount,
   output logic [15:0]                   oDropCount
);

   localparam logic [4:0]            ThisIdBits  = 5'(ThisID);
   localparam logic [5:0]            CmpltOpBits = 6'(CmpltOpcode);
   localparam logic [DepthWidth:0]   FullCount   = (DepthWidth + 1)'(Depth);

   logic [5:0]                    opcodeMem  [Depth];
   logic [4:0]                    targetMem  [Depth];
   logic [4:0]                    sourceMem  [Depth];
   logic [AddressWidth-1:0]       addressMem [Depth];
   logic [InnerIFLengthWidth-1:0] lengthMem  [Depth];

   logic [DepthWidth-1:0] rdPtr;
   logic [DepthWidth-1:0] wrPtr;
   logic [DepthWidth:0]   count;
   logic [15:0]           dropCount;

   logic accept;
   logic isCmplt;
   logic isDrop;
   logic push;
   logic pop;

   logic [5:0]                    pushOpcode;
   logic [4:0]                    pushTarget;
   logic [4:0]                    pushSource;
   logic [AddressWidth-1:0]       pushAddress;
   logic [InnerIFLengthWidth-1:0] pushLength;

   // Ready is deliberately independent of iDstCmdReady: a full queue refuses
   // the source even when the head is being popped in the same cycle.
   assign oSrcCmdReady = (count != FullCount) && iSrcValidCond;
   assign oDstCmdValid = (count != '0);

   assign accept  = iSrcCmdValid && oSrcCmdReady;
   assign isCmplt = (iSrcTargetID == ThisIdBits);
   assign isDrop  = accept && !isCmplt && (iSrcLength == '0);
   assign push    = accept && !isDrop;
   assign pop     = oDstCmdValid && iDstCmdReady;

   always_comb begin
      pushOpcode  = iSrcOpcode;
      pushTarget  = iSrcTargetID;
      pushSource  = iSrcSourceID;
      pushAddress = iSrcAddress;
      pushLength  = iSrcLength;
      if (isCmplt) begin
         pushOpcode = CmpltOpBits;
         pushTarget = (CmpltToSource != 0) ? iSrcSourceID : 5'd0;
         pushSource = ThisIdBits;
         pushLength = InnerIFLengthWidth'(1);
      end
   end

   always_ff @(posedge iClock) begin
      if (iReset) begin
         for (int unsigned i = 0; i < Depth; i++) begin
            opcodeMem[i]  <= '0;
            targetMem[i]  <= '0;
            sourceMem[i]  <= '0;
            addressMem[i] <= '0;
            lengthMem[i]  <= '0;
         end
      end else if (push) begin
         opcodeMem[wrPtr]  <= pushOpcode;
         targetMem[wrPtr]  <= pushTarget;
         sourceMem[wrPtr]  <= pushSource;
         addressMem[wrPtr] <= pushAddress;
         lengthMem[wrPtr]  <= pushLength;
      end
   end

   always_ff @(posedge iClock) begin
      if (iReset) begin
         rdPtr     <= '0;
         wrPtr     <= '0;
         count     <= '0;
         dropCount <= '0;
      end else begin
         if (push) begin
            wrPtr <= wrPtr + 1'b1;
         end
         if (pop) begin
            rdPtr <= rdPtr + 1'b1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (!push && pop) begin
            count <= count - 1'b1;
         end
         if (isDrop && (dropCount != '1)) begin
            dropCount <= dropCount + 1'b1;
         end
      end
   end

   assign oDstOpcode   = opcodeMem[rdPtr];
   assign oDstTargetID = targetMem[rdPtr];
   assign oDstSourceID = sourceMem[rdPtr];
   assign oDstAddress  = addressMem[rdPtr];
   assign oDstLength   = lengthMem[rdPtr];
   assign oQueueCount  = count;
   assign oDropCount   = dropCount;

endmodule

// File: tb/tb_completion_command_channel_fifo.sv
// Bench for completion_command_channel_fifo: a queue-based reference model
// predicts every output; two instances differ only in completion routing.
module tb_completion_command_channel_fifo;

   localparam int Depth = 4;

   typedef struct packed {
      logic [5:0]  op;
      logic [4:0]  tgt;
      logic [4:0]  src;
      logic [31:0] addr;
      logic [15:0] len;
   } ent_t;

   logic iClock = 1'b0;
   logic iReset;
   logic iSrcCmdValid;
   logic iSrcValidCond;
   logic iDstCmdReady;
   ent_t cur;

   logic        oSrcCmdReady, oDstCmdValid;
   logic [5:0]  oDstOpcode;
   logic [4:0]  oDstTargetID, oDstSourceID;
   logic [31:0] oDstAddress;
   logic [15:0] oDstLength;
   logic [2:0]  oQueueCount;
   logic [15:0] oDropCount;

   logic        oSrcCmdReady2, oDstCmdValid2;
   logic [5:0]  oDstOpcode2;
   logic [4:0]  oDstTargetID2, oDstSourceID2;
   logic [31:0] oDstAddress2;
   logic [15:0] oDstLength2;
   logic [2:0]  oQueueCount2;
   logic [15:0] oDropCount2;

   ent_t head1, head2;
   assign head1 = {oDstOpcode, oDstTargetID, oDstSourceID, oDstAddress, oDstLength};
   assign head2 = {oDstOpcode2, oDstTargetID2, oDstSourceID2, oDstAddress2, oDstLength2};

   always #5 iClock = ~iClock;

   completion_command_channel_fifo #(
      .AddressWidth(32), .InnerIFLengthWidth(16), .ThisID(1), .Depth(Depth),
      .DepthWidth(2), .CmpltOpcode(0), .CmpltToSource(0)
   ) dut (
      .iClock(iClock), .iReset(iReset),
      .iSrcOpcode(cur.op), .iSrcTargetID(cur.tgt), .iSrcSourceID(cur.src),
      .iSrcAddress(cur.addr), .iSrcLength(cur.len),
      .iSrcCmdValid(iSrcCmdValid), .oSrcCmdReady(oSrcCmdReady),
      .iSrcValidCond(iSrcValidCond),
      .oDstOpcode(oDstOpcode), .oDstTargetID(oDstTargetID), .oDstSourceID(oDstSourceID),
      .oDstAddress(oDstAddress), .oDstLength(oDstLength),
      .oDstCmdValid(oDstCmdValid), .iDstCmdReady(iDstCmdReady),
      .oQueueCount(oQueueCount), .oDropCount(oDropCount)
   );

   completion_command_channel_fifo #(
      .AddressWidth(32), .InnerIFLengthWidth(16), .ThisID(1), .Depth(Depth),
      .DepthWidth(2), .CmpltOpcode(0), .CmpltToSource(1)
   ) dut2 (
      .iClock(iClock), .iReset(iReset),
      .iSrcOpcode(cur.op), .iSrcTargetID(cur.tgt), .iSrcSourceID(cur.src),
      .iSrcAddress(cur.addr), .iSrcLength(cur.len),
      .iSrcCmdValid(iSrcCmdValid), .oSrcCmdReady(oSrcCmdReady2),
      .iSrcValidCond(iSrcValidCond),
      .oDstOpcode(oDstOpcode2), .oDstTargetID(oDstTargetID2), .oDstSourceID(oDstSourceID2),
      .oDstAddress(oDstAddress2), .oDstLength(oDstLength2),
      .oDstCmdValid(oDstCmdValid2), .iDstCmdReady(iDstCmdReady),
      .oQueueCount(oQueueCount2), .oDropCount(oDropCount2)
   );

   // Reference model
   ent_t        q1[$];
   ent_t        q2[$];
   int unsigned mDrop;
   int          vectors = 0;
   int          miscompares = 0;

   // One clock edge; the model follows the classification rules directly.
   task automatic tick();
      bit   acc;
      bit   pp;
      ent_t e1, e2;
      acc = iSrcCmdValid && iSrcValidCond && (q1.size() != Depth);
      pp  = (q1.size() != 0) && iDstCmdReady;
      @(posedge iClock);
      if (iReset) begin
         q1.delete();
         q2.delete();
         mDrop = 0;
      end else begin
         if (pp) begin
            q1.delete(0);
            q2.delete(0);
         end
         if (acc) begin
            if (cur.tgt == 5'd1) begin
               e1 = '{op: 6'd0, tgt: 5'd0, src: 5'd1, addr: cur.addr, len: 16'd1};
               e2 = e1;
               e2.tgt = cur.src;
               q1.push_back(e1);
               q2.push_back(e2);
            end else if (cur.len == 16'd0) begin
               if (mDrop < 65535) mDrop++;
            end else begin
               q1.push_back(cur);
               q2.push_back(cur);
            end
         end
      end
      #1;
   endtask

   function automatic ent_t rand_ent(bit allowDrop);
      ent_t e;
      e.op   = 6'($urandom);
      e.tgt  = 5'($urandom_range(0, 4));
      e.src  = 5'($urandom);
      e.addr = $urandom;
      e.len  = 16'($urandom);
      if (allowDrop && ($urandom_range(0, 3) == 0)) e.len = 16'd0;
      if (!allowDrop && e.len == 16'd0) e.len = 16'd5;
      return e;
   endfunction

   task automatic test_reset();
      iReset = 1'b1; iSrcCmdValid = 1'b0; iSrcValidCond = 1'b1; iDstCmdReady = 1'b0;
      cur = '0;
      tick();
      iReset = 1'b0;
      tick();
      vectors++;
      if (oDstCmdValid !== 1'b0) begin
         miscompares++; $display("FAIL reset_valid got %b want 0", oDstCmdValid);
      end
      vectors++;
      if (oQueueCount !== 3'd0) begin
         miscompares++; $display("FAIL reset_count got %0d want 0", oQueueCount);
      end
      vectors++;
      if (oDropCount !== 16'd0) begin
         miscompares++; $display("FAIL reset_drop got %0d want 0", oDropCount);
      end
      vectors++;
      if (oSrcCmdReady !== 1'b1) begin
         miscompares++; $display("FAIL reset_ready got %b want 1", oSrcCmdReady);
      end
   endtask

   task automatic test_forward();
      ent_t want;
      want = '{op: 6'h12, tgt: 5'd3, src: 5'd2, addr: 32'h1000, len: 16'd8};
      cur = want; iSrcCmdValid = 1'b1; iDstCmdReady = 1'b0;
      tick();
      iSrcCmdValid = 1'b0;
      vectors++;
      if (head1 !== want || oDstCmdValid !== 1'b1) begin
         miscompares++; $display("FAIL forward_head got %h/%b want %h/1", head1, oDstCmdValid, want);
      end
      vectors++;
      if (oQueueCount !== 3'd1) begin
         miscompares++; $display("FAIL forward_count got %0d want 1", oQueueCount);
      end
      iDstCmdReady = 1'b1;
      tick();
      iDstCmdReady = 1'b0;
   endtask

   task automatic test_completion();
      ent_t want1, want2;
      want1 = '{op: 6'd0, tgt: 5'd0, src: 5'd1, addr: 32'hABC0, len: 16'd1};
      want2 = '{op: 6'd0, tgt: 5'd7, src: 5'd1, addr: 32'hABC0, len: 16'd1};
      cur = '{op: 6'h2A, tgt: 5'd1, src: 5'd7, addr: 32'hABC0, len: 16'd0};
      iSrcCmdValid = 1'b1;
      tick();
      iSrcCmdValid = 1'b0;
      vectors++;
      if (head1 !== want1) begin
         miscompares++; $display("FAIL cmplt_target0 got %h want %h", head1, want1);
      end
      vectors++;
      if (head2 !== want2) begin
         miscompares++; $display("FAIL cmplt_to_source got %h want %h", head2, want2);
      end
      vectors++;
      if (oDropCount !== 16'd0) begin
         miscompares++; $display("FAIL cmplt_no_drop got %0d want 0", oDropCount);
      end
      iDstCmdReady = 1'b1;
      tick();
      iDstCmdReady = 1'b0;
   endtask

   task automatic test_drop();
      cur = '{op: 6'h05, tgt: 5'd4, src: 5'd2, addr: 32'h40, len: 16'd0};
      iSrcCmdValid = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      iSrcCmdValid = 1'b0;
      vectors++;
      if (oDropCount !== 16'(mDrop) || mDrop != 3) begin
         miscompares++; $display("FAIL drop_count got %0d want 3", oDropCount);
      end
      vectors++;
      if (oQueueCount !== 3'd0 || oDstCmdValid !== 1'b0) begin
         miscompares++; $display("FAIL drop_noqueue got %0d/%b want 0/0", oQueueCount, oDstCmdValid);
      end
      force dut.dropCount = 16'hFFFE;
      #1;
      release dut.dropCount;
      mDrop = 32'hFFFE;
      iSrcCmdValid = 1'b1;
      tick();
      vectors++;
      if (oDropCount !== 16'hFFFF) begin
         miscompares++; $display("FAIL drop_reach_max got %h want ffff", oDropCount);
      end
      tick();
      iSrcCmdValid = 1'b0;
      vectors++;
      if (oDropCount !== 16'(mDrop)) begin
         miscompares++; $display("FAIL drop_saturate got %h want %h", oDropCount, 16'(mDrop));
      end
   endtask

   task automatic test_full_wrap();
      int guard;
      iDstCmdReady = 1'b0;
      for (int i = 0; i < Depth; i++) begin
         cur = rand_ent(1'b0); iSrcCmdValid = 1'b1;
         tick();
      end
      vectors++;
      if (oQueueCount !== 3'(Depth) || q1.size() != Depth) begin
         miscompares++; $display("FAIL full_count got %0d want %0d", oQueueCount, Depth);
      end
      cur = rand_ent(1'b0); iDstCmdReady = 1'b1;
      #1;
      vectors++;
      if (oSrcCmdReady !== 1'b0) begin
         miscompares++; $display("FAIL full_ready_with_pop got %b want 0", oSrcCmdReady);
      end
      tick();
      iSrcCmdValid = 1'b0;
      #1;
      vectors++;
      if (oQueueCount !== 3'(q1.size()) || oSrcCmdReady !== 1'b1) begin
         miscompares++; $display("FAIL after_pop got %0d/%b want %0d/1", oQueueCount, oSrcCmdReady, q1.size());
      end
      guard = 0;
      while (q1.size() != 0 && guard < 2 * Depth) begin
         vectors++;
         if (head1 !== q1[0] || oDstCmdValid !== 1'b1) begin
            miscompares++; $display("FAIL wrap_order got %h want %h", head1, q1[0]);
         end
         tick();
         guard++;
      end
      vectors++;
      if (oDstCmdValid !== 1'b0 || q1.size() != 0) begin
         miscompares++; $display("FAIL wrap_drain got valid %b want 0", oDstCmdValid);
      end
      iDstCmdReady = 1'b0;
   endtask

   task automatic test_back_to_back();
      iDstCmdReady = 1'b0;
      for (int i = 0; i < 2; i++) begin
         cur = rand_ent(1'b0); iSrcCmdValid = 1'b1;
         tick();
      end
      iDstCmdReady = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cur = rand_ent(1'b0);
         vectors++;
         if (oQueueCount !== 3'd2 || head1 !== q1[0]) begin
            miscompares++; $display("FAIL b2b_cycle%0d got %0d/%h want 2/%h", i, oQueueCount, head1, q1[0]);
         end
         tick();
      end
      iSrcCmdValid = 1'b0;
      for (int i = 0; i < 2; i++) tick();
      iDstCmdReady = 1'b0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         vectors++;
         if (oQueueCount !== 3'(q1.size()) || oDstCmdValid !== (q1.size() != 0)
             || oDropCount !== 16'(mDrop)) begin
            miscompares++;
            $display("FAIL rand_state%0d got cnt %0d vld %b drop %0d want %0d/%0d",
                     i, oQueueCount, oDstCmdValid, oDropCount, q1.size(), mDrop);
         end
         if (q1.size() != 0) begin
            vectors++;
            if (head1 !== q1[0] || head2 !== q2[0]) begin
               miscompares++; $display("FAIL rand_head%0d got %h/%h want %h/%h", i, head1, head2, q1[0], q2[0]);
            end
         end
         cur = rand_ent(1'b1);
         iSrcCmdValid  = ($urandom_range(0, 3) != 0);
         iSrcValidCond = ($urandom_range(0, 4) != 0);
         iDstCmdReady  = ($urandom_range(0, 2) == 0);
         #1;
         vectors++;
         if (oSrcCmdReady !== ((q1.size() != Depth) && iSrcValidCond)) begin
            miscompares++; $display("FAIL rand_ready%0d got %b", i, oSrcCmdReady);
         end
         tick();
      end
      iSrcCmdValid = 1'b0; iSrcValidCond = 1'b1; iDstCmdReady = 1'b0;
   endtask

   task automatic test_reset_mid();
      iDstCmdReady = 1'b1;
      iSrcCmdValid = 1'b0;
      for (int i = 0; i < Depth + 1; i++) tick();
      iDstCmdReady = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cur = rand_ent(1'b0); iSrcCmdValid = 1'b1;
         tick();
      end
      vectors++;
      if (oQueueCount !== 3'd3) begin
         miscompares++; $display("FAIL pre_reset_count got %0d want 3", oQueueCount);
      end
      cur = rand_ent(1'b0);
      iReset = 1'b1; iDstCmdReady = 1'b1;
      tick();
      iReset = 1'b0; iSrcCmdValid = 1'b0; iDstCmdReady = 1'b0;
      vectors++;
      if (oQueueCount !== 3'd0 || oDstCmdValid !== 1'b0) begin
         miscompares++; $display("FAIL mid_reset got %0d/%b want 0/0", oQueueCount, oDstCmdValid);
      end
      vectors++;
      if (head1 !== '0 || oDropCount !== 16'd0) begin
         miscompares++; $display("FAIL mid_reset_clear got %h/%0d want 0/0", head1, oDropCount);
      end
   endtask

   initial begin
      test_reset();
      test_forward();
      test_completion();
      test_drop();
      test_full_wrap();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
